// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : pc_sequencer
// Purpose  : Parametrised program counter for the instruction memory. Provides
//            a boot cycle, increment, absolute load, call/return through a
//            return-address stack (RAS) and halt/resume.
// Options  : `define PC_RAS_EN to build the return-address stack. Without it
//            CALL acts as LOAD, RET holds the PC, StackErr/StackLevel read 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
  parameter int unsigned         ADDR_W       = 10,
  parameter logic [ADDR_W-1:0]   RESET_VECTOR = '0,
  parameter int unsigned         RAS_DEPTH    = 4
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           PCFunct,
  input  logic [1:0]                     PCOp,
  input  logic [ADDR_W-1:0]              InstrucaoModificada,
  input  logic                           Halt,
  input  logic                           Resume,
  output logic [ADDR_W-1:0]              Instrucao,
  output logic                           Running,
  output logic                           StackErr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] StackLevel
);

  localparam int unsigned LW = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t              state_q;
  logic                running_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic [ADDR_W-1:0]   pc_inc;
  logic                upd;

  // An update happens only in RUN when no halt is requested this edge.
  assign upd    = (state_q == ST_RUN) && !Halt && PCFunct;
  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef PC_RAS_EN
  localparam int unsigned       IW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [LW-1:0]     FULL = LW'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_q [0:RAS_DEPTH-1];
  logic [LW-1:0]     level_q, level_d;
  logic              err_q, err_d;
  logic              push_d;
  logic [LW-1:0]     top_idx;

  assign top_idx = level_q - LW'(1);

  // Next PC and stack bookkeeping; overflow drops the push, underflow holds PC.
  always_comb begin
    pc_d    = pc_q;
    level_d = level_q;
    err_d   = err_q;
    push_d  = 1'b0;
    if (upd) begin
      case (PCOp)
        OP_INC:  pc_d = pc_inc;
        OP_LOAD: pc_d = InstrucaoModificada;
        OP_CALL: begin
          pc_d = InstrucaoModificada;
          if (level_q == FULL) begin
            err_d = 1'b1;
          end else begin
            push_d  = 1'b1;
            level_d = level_q + LW'(1);
          end
        end
        default: begin
          if (level_q == '0) begin
            err_d = 1'b1;
          end else begin
            pc_d    = ras_q[top_idx[IW-1:0]];
            level_d = top_idx;
          end
        end
      endcase
    end
  end

  // Stack storage: contents are don't-care after reset, so no reset needed.
  always_ff @(posedge Clock) begin
    if (push_d) begin
      ras_q[level_q[IW-1:0]] <= pc_inc;
    end
  end

  // Stack level and sticky error flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  assign StackLevel = level_q;
  assign StackErr   = err_q;
`else
  // Next PC without a stack: CALL loads the target, RET leaves the PC alone.
  always_comb begin
    pc_d = pc_q;
    if (upd) begin
      case (PCOp)
        OP_INC:  pc_d = pc_inc;
        OP_LOAD: pc_d = InstrucaoModificada;
        OP_CALL: pc_d = InstrucaoModificada;
        default: pc_d = pc_q;
      endcase
    end
  end

  assign StackLevel = '0;
  assign StackErr   = 1'b0;
`endif

  // Control FSM with registered Running and PC; BOOT always lasts one edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_BOOT;
      running_q <= 1'b0;
      pc_q      <= RESET_VECTOR;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end
        ST_RUN: begin
          if (Halt) begin
            state_q   <= ST_HALT;
            running_q <= 1'b0;
          end else begin
            pc_q <= pc_d;
          end
        end
        ST_HALT: begin
          if (Resume && !Halt) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_BOOT;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign Instrucao = pc_q;
  assign Running   = running_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer (ADDR_W=4,
//            RAS_DEPTH=2). Stack expectations follow PC_RAS_EN if defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       pcfunct;
  logic [1:0] pcop;
  logic [3:0] tgt;
  logic       halt;
  logic       resume;
  logic [3:0] pc;
  logic       running;
  logic       serr;
  logic [1:0] slevel;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] INC  = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] CALL = 2'b10;
  localparam logic [1:0] RET  = 2'b11;

  pc_sequencer #(
    .ADDR_W       (4),
    .RESET_VECTOR (4'd0),
    .RAS_DEPTH    (2)
  ) dut (
    .Clock               (clk),
    .Reset               (rst),
    .PCFunct             (pcfunct),
    .PCOp                (pcop),
    .InstrucaoModificada (tgt),
    .Halt                (halt),
    .Resume              (resume),
    .Instrucao           (pc),
    .Running             (running),
    .StackErr            (serr),
    .StackLevel          (slevel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply a request, let one rising edge pass, return at the falling edge.
  task automatic op(input logic f, input logic [1:0] o, input logic [3:0] t);
    pcfunct = f;
    pcop    = o;
    tgt     = t;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pcfunct = 1'b1; pcop = INC; tgt = 4'd0; halt = 1'b0; resume = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_run", running, 0);
    check("rst_lvl", slevel, 0);
    check("rst_err", serr, 0);
    rst = 1'b0;

    // Boot edge ignores INC, then counting starts.
    @(negedge clk);
    check("boot_pc", pc, 0);
    check("boot_run", running, 1);
    op(1'b1, INC, 4'd0); check("inc1", pc, 1);
    op(1'b1, INC, 4'd0); check("inc2", pc, 2);
    op(1'b1, INC, 4'd0); check("inc3", pc, 3);

    // Wrap, load, hold.
    op(1'b1, LOAD, 4'd14); check("load14", pc, 14);
    op(1'b1, INC, 4'd0);   check("inc15", pc, 15);
    op(1'b1, INC, 4'd0);   check("wrap0", pc, 0);
    op(1'b1, LOAD, 4'd9);  check("load9", pc, 9);
    op(1'b0, INC, 4'd3);   check("hold9a", pc, 9);
    op(1'b0, LOAD, 4'd3);  check("hold9b", pc, 9);

    // Call / return.
    op(1'b1, LOAD, 4'd5);
`ifdef PC_RAS_EN
    op(1'b1, CALL, 4'd12); check("call_pc", pc, 12); check("call_lvl", slevel, 1);
    op(1'b1, RET, 4'd0);   check("ret_pc", pc, 6);   check("ret_lvl", slevel, 0);
    check("ret_err", serr, 0);
    op(1'b1, LOAD, 4'd3);
    op(1'b1, CALL, 4'd8);  check("c1_lvl", slevel, 1);
    op(1'b1, CALL, 4'd10); check("c2_pc", pc, 10); check("c2_lvl", slevel, 2);
    check("c2_err", serr, 0);
    op(1'b1, CALL, 4'd13); check("ovf_pc", pc, 13); check("ovf_lvl", slevel, 2);
    check("ovf_err", serr, 1);
    op(1'b1, RET, 4'd0);   check("r1_pc", pc, 9);  check("r1_lvl", slevel, 1);
    op(1'b1, RET, 4'd0);   check("r2_pc", pc, 4);  check("r2_lvl", slevel, 0);
    op(1'b1, RET, 4'd0);   check("unf_pc", pc, 4); check("unf_lvl", slevel, 0);
    check("unf_err", serr, 1);
`else
    op(1'b1, CALL, 4'd12); check("call_pc", pc, 12); check("call_lvl", slevel, 0);
    op(1'b1, RET, 4'd0);   check("ret_hold", pc, 12); check("ret_err", serr, 0);
`endif

    // Halt / resume.
    op(1'b1, LOAD, 4'd7);
    halt = 1'b1;
    op(1'b1, INC, 4'd0); check("halt_pc", pc, 7); check("halt_run", running, 0);
    halt = 1'b0;
    op(1'b1, INC, 4'd0); check("halted_pc", pc, 7); check("halted_run", running, 0);
    halt = 1'b1; resume = 1'b1;
    op(1'b1, INC, 4'd0); check("hr_both_run", running, 0); check("hr_both_pc", pc, 7);
    halt = 1'b0;
    op(1'b1, INC, 4'd0); check("resume_run", running, 1); check("resume_pc", pc, 7);
    resume = 1'b0;
    op(1'b1, INC, 4'd0); check("post_res", pc, 8);

    // Asynchronous reset in the middle of a call.
`ifdef PC_RAS_EN
    op(1'b1, CALL, 4'd2);
    op(1'b1, CALL, 4'd3);
    check("pre_rst_lvl", slevel, 2);
    check("pre_rst_err", serr, 1);
`endif
    pcfunct = 1'b1; pcop = CALL; tgt = 4'd11;
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc, 0);
    check("arst_lvl", slevel, 0);
    check("arst_err", serr, 0);
    check("arst_run", running, 0);
    @(negedge clk);
    check("arst_hold", pc, 0);
    rst = 1'b0; pcop = INC;
    @(negedge clk);
    check("reboot_pc", pc, 0);
    check("reboot_run", running, 1);
    op(1'b1, INC, 4'd0); check("reboot_inc", pc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
